rft_core_scheduler: RTL and testbench

RFT_CORE_SCHEDULER -- requirements
Module: rft_core_scheduler

---
 rtl/rft_sched_pkg.sv | 25 ++
 rtl/rft_rr_arbiter.sv | 31 +++
 rtl/rft_core_scheduler.sv | 168 ++++++++++++++++
 tb/tb_rft_core_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rft_sched_pkg.sv
// rtl/rft_sched_pkg.sv - shared types and default constants for the phi_rft_core scheduler
package rft_sched_pkg;

   localparam int DEFAULT_NUM_REQ        = 4;
   localparam int DEFAULT_SAMPLE_WIDTH   = 16;
   localparam int DEFAULT_BLOCK_SAMPLES  = 8;
   localparam int DEFAULT_DIGEST_WIDTH   = 256;
   localparam int DEFAULT_TIMEOUT_CYCLES = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_t;

   // Response record sized for the default configuration.
   typedef struct packed {
      logic [$clog2(DEFAULT_NUM_REQ)-1:0] id;
      logic [DEFAULT_DIGEST_WIDTH-1:0]    digest;
      logic                               resonance;
      logic                               error;
   } sched_rsp_t;

endpackage

// File: rtl/rft_rr_arbiter.sv
// rtl/rft_rr_arbiter.sv - combinational round-robin picker: first request at or after rr_ptr
module rft_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int               j;
         logic [IDX_W-1:0] jj;
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = IDX_W'(j);
         if (!grant_any && req[jj]) begin
            grant[jj] = 1'b1;
            grant_idx = jj;
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rft_core_scheduler.sv
// rtl/rft_core_scheduler.sv - shares one phi_rft_core among NUM_REQ requesters, one job in flight
// Optional WAIT watchdog enabled by defining RFT_SCHED_TIMEOUT_EN.
module rft_core_scheduler
   import rft_sched_pkg::*;
#(
   parameter int NUM_REQ         = DEFAULT_NUM_REQ,
   parameter int SAMPLE_WIDTH_P  = DEFAULT_SAMPLE_WIDTH,
   parameter int BLOCK_SAMPLES_P = DEFAULT_BLOCK_SAMPLES,
   parameter int DIGEST_WIDTH_P  = DEFAULT_DIGEST_WIDTH,
   parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic [NUM_REQ-1:0]                                 req_valid,
   output logic [NUM_REQ-1:0]                                 req_ready,
   input  logic [NUM_REQ*BLOCK_SAMPLES_P*SAMPLE_WIDTH_P-1:0]  req_samples,
   input  logic [NUM_REQ*4-1:0]                               req_mode,
   output logic                                               core_start,
   output logic [BLOCK_SAMPLES_P*SAMPLE_WIDTH_P-1:0]          core_samples,
   output logic [3:0]                                         core_mode,
   input  logic                                               core_busy,
   input  logic                                               core_digest_valid,
   input  logic                                               core_resonance,
   input  logic [DIGEST_WIDTH_P-1:0]                          core_digest,
   output logic                                               rsp_valid,
   input  logic                                               rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]                         rsp_id,
   output logic [DIGEST_WIDTH_P-1:0]                          rsp_digest,
   output logic                                               rsp_resonance,
   output logic                                               rsp_error
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int BLK_W = BLOCK_SAMPLES_P * SAMPLE_WIDTH_P;

   sched_state_t       state, state_next;
   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_any;
   logic               accept, digest_hit, rsp_done;
   logic [BLK_W-1:0]   sel_samples;
   logic [3:0]         sel_mode;

   rft_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   always_comb begin
      sel_samples = '0;
      sel_mode    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_samples = req_samples[i*BLK_W +: BLK_W];
            sel_mode    = req_mode[i*4 +: 4];
         end
      end
   end

`ifdef RFT_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             timeout_hit;

   // A digest arriving on the last allowed cycle still wins over the timeout.
   assign timeout_hit = (state == ST_WAIT) && !core_digest_valid &&
                        (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 tmo_cnt <= '0;
      else if (state == ST_ISSUE) tmo_cnt <= '0;
      else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + CNT_W'(1);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = '0;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      accept     = 1'b0;
      digest_hit = 1'b0;
      rsp_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            // rst_n gating keeps req_ready low while reset is held.
            if (rst_n && !core_busy && grant_any) begin
               req_ready  = grant;
               accept     = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_start = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_digest_valid) begin
               digest_hit = 1'b1;
               state_next = ST_RESP;
            end
`ifdef RFT_SCHED_TIMEOUT_EN
            else if (timeout_hit) begin
               state_next = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_done   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_samples  <= '0;
         core_mode     <= '0;
         rsp_id        <= '0;
         rsp_digest    <= '0;
         rsp_resonance <= 1'b0;
         rr_ptr        <= '0;
      end else begin
         if (accept) begin
            core_samples <= sel_samples;
            core_mode    <= sel_mode;
            rsp_id       <= grant_idx;
         end
         if (digest_hit) begin
            rsp_digest    <= core_digest;
            rsp_resonance <= core_resonance;
         end
`ifdef RFT_SCHED_TIMEOUT_EN
         if (timeout_hit) begin
            rsp_digest    <= '0;
            rsp_resonance <= 1'b0;
         end
`endif
         if (rsp_done) begin
            rr_ptr <= (rsp_id == IDX_W'(NUM_REQ - 1)) ? '0 : rsp_id + IDX_W'(1);
         end
      end
   end

`ifdef RFT_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          rsp_error <= 1'b0;
      else if (accept)     rsp_error <= 1'b0;
      else if (timeout_hit) rsp_error <= 1'b1;
   end
`else
   assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_rft_core_scheduler.sv
// tb/tb_rft_core_scheduler.sv - randomized self-checking bench with round-robin reference model
module tb_rft_core_scheduler;
   import rft_sched_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [511:0] req_samples;
   logic [15:0]  req_mode;
   logic         core_start;
   logic [127:0] core_samples;
   logic [3:0]   core_mode;
   logic         core_busy;
   logic         core_digest_valid;
   logic         core_resonance;
   logic [255:0] core_digest;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [255:0] rsp_digest;
   logic         rsp_resonance;
   logic         rsp_error;

   int n_total = 0;
   int n_pass  = 0;
   int exp_ptr = 0;

   always #5 clk = ~clk;

   rft_core_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_samples(req_samples), .req_mode(req_mode),
      .core_start(core_start), .core_samples(core_samples), .core_mode(core_mode),
      .core_busy(core_busy), .core_digest_valid(core_digest_valid),
      .core_resonance(core_resonance), .core_digest(core_digest),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_digest(rsp_digest), .rsp_resonance(rsp_resonance), .rsp_error(rsp_error)
   );

   // Reference rule: first requester at or after the pointer, wrapping.
   function automatic int model_grant(input logic [3:0] m, input int p);
      for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // Runs one complete job from IDLE; entered and left shortly after a rising edge.
   task automatic run_job(input logic [3:0] mask, input int busy_pre, input int delay,
                          input int bp, input bit keep, output int gid);
      sched_rsp_t   exp;
      logic [127:0] exp_samp;
      logic [3:0]   exp_mode;
      logic [3:0]   exp_ready;
      int g;
      core_busy = 1'b1;
      req_valid = mask;
      for (int b = 0; b < busy_pre; b++) begin
         #1;
         n_total++;
         if (req_ready !== 4'b0) $display("FAIL busy_gate got %b exp 0000", req_ready); else n_pass++;
         @(posedge clk); #1;
      end
      core_busy = 1'b0;
      #1;
      g = model_grant(mask, exp_ptr);
      exp_ready = 4'b0;
      exp_ready[g] = 1'b1;
      n_total++;
      if (req_ready !== exp_ready) $display("FAIL grant got %b exp %b", req_ready, exp_ready); else n_pass++;
      exp_samp = req_samples[g*128 +: 128];
      exp_mode = req_mode[g*4 +: 4];
      @(posedge clk); #1;
      if (!keep) req_valid = 4'b0;
      core_busy = 1'b1;
      #1;
      n_total++;
      if (core_start !== 1'b1) $display("FAIL issue_start got %b exp 1", core_start); else n_pass++;
      n_total++;
      if (core_samples !== exp_samp || core_mode !== exp_mode)
         $display("FAIL issue_payload got %h/%h exp %h/%h", core_samples, core_mode, exp_samp, exp_mode);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (core_start !== 1'b0) $display("FAIL start_one_cycle got %b exp 0", core_start); else n_pass++;
      for (int d = 0; d < delay; d++) begin
         n_total++;
         if (rsp_valid !== 1'b0 || req_ready !== 4'b0)
            $display("FAIL wait_quiet got %b/%b exp 0/0000", rsp_valid, req_ready);
         else n_pass++;
         @(posedge clk); #1;
      end
      exp.id        = 2'(g);
      exp.digest    = rand256();
      exp.resonance = 1'($urandom());
      exp.error     = 1'b0;
      core_digest       = exp.digest;
      core_resonance    = exp.resonance;
      core_digest_valid = 1'b1;
      @(posedge clk); #1;
      core_digest_valid = 1'b0;
      core_busy         = 1'b0;
      core_digest       = rand256();
      core_resonance    = ~exp.resonance;
      rsp_ready         = (bp == 0);
      #1;
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp.id || rsp_digest !== exp.digest ||
          rsp_resonance !== exp.resonance || rsp_error !== exp.error || req_ready !== 4'b0)
         $display("FAIL response got v%b id%0d r%b e%b rdy%b %h exp v1 id%0d r%b e0 rdy0000 %h",
                  rsp_valid, rsp_id, rsp_resonance, rsp_error, req_ready, rsp_digest,
                  exp.id, exp.resonance, exp.digest);
      else n_pass++;
      for (int b = 0; b < bp; b++) begin
         @(posedge clk); #1;
         n_total++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp.id || rsp_digest !== exp.digest ||
             rsp_resonance !== exp.resonance || req_ready !== 4'b0 || core_start !== 1'b0)
            $display("FAIL backpressure got v%b id%0d rdy%b st%b exp v1 id%0d rdy0000 st0",
                     rsp_valid, rsp_id, req_ready, core_start, exp.id);
         else n_pass++;
         if (b == bp - 1) rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL rsp_drop got %b exp 0", rsp_valid); else n_pass++;
      exp_ptr = (g + 1) % 4;
      gid = g;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_ptr = 0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 4'hF; core_busy = 1'b0; core_digest_valid = 1'b0; core_resonance = 1'b0;
      core_digest = '0; rsp_ready = 1'b0; req_mode = 16'hFFFF;
      for (int i = 0; i < 16; i++) req_samples[i*32 +: 32] = $urandom();
      #2;
      n_total++;
      if (req_ready !== 4'b0 || core_start !== 1'b0 || rsp_valid !== 1'b0)
         $display("FAIL reset_ctrl got %b/%b/%b exp 0000/0/0", req_ready, core_start, rsp_valid);
      else n_pass++;
      n_total++;
      if (core_samples !== '0 || core_mode !== 4'b0)
         $display("FAIL reset_core got %h/%h exp 0/0", core_samples, core_mode);
      else n_pass++;
      n_total++;
      if (rsp_id !== 2'b0 || rsp_digest !== '0 || rsp_resonance !== 1'b0 || rsp_error !== 1'b0)
         $display("FAIL reset_rsp got %0d/%h/%b/%b exp 0/0/0/0", rsp_id, rsp_digest, rsp_resonance, rsp_error);
      else n_pass++;
      req_valid = 4'b0;
      apply_reset();
   endtask

   task automatic test_single();
      int gid;
      for (int i = 0; i < 32; i++) req_samples[i*16 +: 16] = 16'h28BA;
      req_mode = 16'h1111;
      run_job(4'b0100, 0, 3, 0, 1'b0, gid);
      n_total++;
      if (gid !== 2) $display("FAIL single_id got %0d exp 2", gid); else n_pass++;
   endtask

   task automatic test_round_robin();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      int gid;
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 16; i++) req_samples[i*32 +: 32] = $urandom();
         req_mode = 16'($urandom());
         run_job(4'hF, 0, 1, 0, 1'b1, gid);
         n_total++;
         if (gid !== exp_seq[k]) $display("FAIL rr_order[%0d] got %0d exp %0d", k, gid, exp_seq[k]); else n_pass++;
      end
      req_valid = 4'b0;
   endtask

   task automatic test_backpressure();
      int gid;
      run_job(4'b1001, 0, 2, 5, 1'b0, gid);
   endtask

   task automatic test_random();
      int gid;
      logic [3:0] m;
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 16; i++) req_samples[i*32 +: 32] = $urandom();
         req_mode = 16'($urandom());
         m = 4'($urandom_range(1, 15));
         run_job(m, $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0, gid);
      end
   endtask

   task automatic test_stray_digest();
      req_valid = 4'b0;
      core_digest = rand256();
      core_digest_valid = 1'b1;
      @(posedge clk); #1;
      core_digest_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_total++;
         if (rsp_valid !== 1'b0 || core_start !== 1'b0)
            $display("FAIL stray_digest got %b/%b exp 0/0", rsp_valid, core_start);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midjob();
      int gid;
      for (int i = 0; i < 16; i++) req_samples[i*32 +: 32] = $urandom() | 32'h1;
      req_mode = 16'hFFFF;
      req_valid = 4'b0010;
      core_busy = 1'b0;
      #1;
      @(posedge clk); #1;
      req_valid = 4'b0;
      core_busy = 1'b1;
      n_total++;
      if (core_start !== 1'b1) $display("FAIL abort_start got %b exp 1", core_start); else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      req_valid = 4'hF;
      core_busy = 1'b0;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (core_start !== 1'b0 || core_samples !== '0 || core_mode !== 4'b0 ||
          rsp_valid !== 1'b0 || req_ready !== 4'b0)
         $display("FAIL abort_outputs got %b/%h/%h/%b/%b exp all 0",
                  core_start, core_samples, core_mode, rsp_valid, req_ready);
      else n_pass++;
      @(posedge clk); @(posedge clk); #1;
      req_valid = 4'b0;
      rst_n = 1'b1;
      exp_ptr = 0;
      core_digest = rand256();
      core_digest_valid = 1'b1;
      @(posedge clk); #1;
      core_digest_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_total++;
         if (rsp_valid !== 1'b0) $display("FAIL abort_no_rsp got %b exp 0", rsp_valid); else n_pass++;
         @(posedge clk); #1;
      end
      run_job(4'hF, 0, 1, 0, 1'b0, gid);
      n_total++;
      if (gid !== 0) $display("FAIL abort_ptr got %0d exp 0", gid); else n_pass++;
   endtask

`ifdef RFT_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      req_valid = 4'b1000;
      core_busy = 1'b0;
      #1;
      @(posedge clk); #1;
      req_valid = 4'b0;
      core_busy = 1'b1;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      n_total++;
      if (n !== 33) $display("FAIL timeout_latency got %0d exp 33", n); else n_pass++;
      n_total++;
      if (rsp_error !== 1'b1 || rsp_digest !== '0 || rsp_resonance !== 1'b0 || rsp_id !== 2'd3)
         $display("FAIL timeout_rsp got e%b r%b id%0d %h exp e1 r0 id3 0", rsp_error, rsp_resonance, rsp_id, rsp_digest);
      else n_pass++;
      core_busy = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      exp_ptr = 0;
   endtask
`else
   task automatic test_no_timeout();
      int gid;
      run_job(4'b1000, 0, 40, 0, 1'b0, gid);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_stray_digest();
      test_random();
      test_reset_midjob();
`ifdef RFT_SCHED_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end

endmodule
